bcd_addsub_seq: RTL

// - Digit-serial, sign-magnitude BCD adder/subtractor with a valid/ready handshake on both sides.
// - Parametrised in digit count. Result feeds the display path as {sign digit, BCD magnitude}.
// - Adds saturation, overflow/error flags, a sequential datapath and backpressure.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_addsub_seq_if.sv | 28 ++
 rtl/bcd_digit_adder.sv | 19 +
 rtl/bcd_addsub_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial sign-magnitude BCD adder/subtractor.
// A sign digit equal to the negative code means negative; any other value means positive.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam digit_t NEG_CODE_DEFAULT = 4'd10;

  function automatic logic neg(input digit_t sign, input digit_t code = NEG_CODE_DEFAULT);
    return sign == code;
  endfunction

  // Output sign digit: a zero magnitude is always reported as positive.
  function automatic digit_t sign_digit(input logic negative, input logic nonzero,
                                        input digit_t code);
    return (negative && nonzero) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/bcd_addsub_seq_if.sv
// Operand/result handshake bundle for bcd_addsub_seq.
// The master supplies operands and consumes results; the slave is the arithmetic block.
interface bcd_addsub_seq_if #(
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  op_sub;
  logic [3:0]            a_sign;
  logic [4*DIGITS-1:0]   a_mag;
  logic [3:0]            b_sign;
  logic [4*DIGITS-1:0]   b_mag;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS+3:0]   res;
  logic                  ovf;
  logic                  err;

  modport master (
    output in_valid, op_sub, a_sign, a_mag, b_sign, b_mag, out_ready,
    input  in_ready, out_valid, res, ovf, err
  );

  modport slave (
    input  in_valid, op_sub, a_sign, a_mag, b_sign, b_mag, out_ready,
    output in_ready, out_valid, res, ovf, err
  );
endinterface

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with decimal (+6) correction; used for both the
// magnitude pass and the ten's-complement fix-up pass.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  input  logic   cin,
  output digit_t sum,
  output logic   cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  assign raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign adj  = raw + 5'd6;
  assign cout = raw > 5'd9;
  assign sum  = cout ? adj[3:0] : raw[3:0];
endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial sign-magnitude BCD adder/subtractor: LSD-first magnitude pass,
// optional ten's-complement pass when |a| < |b| under effective subtraction.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int     DIGITS   = 3,
  parameter digit_t NEG_CODE = NEG_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  bcd_addsub_seq_if.slave  bus
);
  localparam int MW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS + 1 > 1) ? $clog2(DIGITS + 1) : 1;

  state_t              state_reg;
  logic [MW-1:0]       a_reg;
  logic [MW-1:0]       b_reg;
  logic [MW-1:0]       r_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                carry_reg;
  logic                eff_sub_reg;
  logic                a_neg_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                ovf_reg;
  logic                err_reg;
  logic [MW+3:0]       res_reg;

  digit_t              add_a;
  digit_t              add_b;
  digit_t              sum;
  logic                cout;
  logic [MW-1:0]       r_shift;
  logic [2*DIGITS-1:0] digit_bad;
  logic                in_bad;
  logic                last_digit;
  logic                r_nonzero;
  logic                eff_sub_in;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign digit_bad[2*gi]   = bus.a_mag[4*gi +: 4] > 4'd9;
      assign digit_bad[2*gi+1] = bus.b_mag[4*gi +: 4] > 4'd9;
    end
    // New digit enters at the MSD end so the LSD lands at the bottom after DIGITS steps.
    if (DIGITS > 1) begin : g_shift
      assign r_shift = {sum, r_reg[MW-1:4]};
    end else begin : g_shift_one
      assign r_shift = sum;
    end
  endgenerate

  assign in_bad     = |digit_bad;
  assign last_digit = idx_reg == IDX_W'(DIGITS - 1);
  assign r_nonzero  = |r_shift;
  assign eff_sub_in = neg(bus.a_sign, NEG_CODE) ^ neg(bus.b_sign, NEG_CODE) ^ bus.op_sub;

  always_comb begin
    add_a = a_reg[3:0];
    add_b = eff_sub_reg ? (4'd9 - b_reg[3:0]) : b_reg[3:0];
    if (state_reg == FIX) begin
      add_a = 4'd9 - r_reg[3:0];
      add_b = 4'd0;
    end
  end

  bcd_digit_adder u_digit (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      eff_sub_reg   <= 1'b0;
      a_neg_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      res_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_reg <= 1'b0;
            a_reg        <= bus.a_mag;
            b_reg        <= bus.b_mag;
            eff_sub_reg  <= eff_sub_in;
            a_neg_reg    <= neg(bus.a_sign, NEG_CODE);
            carry_reg    <= eff_sub_in;
            idx_reg      <= '0;
            if (in_bad) begin
              res_reg       <= '0;
              err_reg       <= 1'b1;
              ovf_reg       <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          r_reg     <= r_shift;
          carry_reg <= cout;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (last_digit) begin
            idx_reg <= '0;
            if (!eff_sub_reg) begin
              // Final carry on an add means the magnitude does not fit: saturate.
              err_reg       <= 1'b0;
              ovf_reg       <= cout;
              res_reg       <= cout ? {sign_digit(a_neg_reg, 1'b1, NEG_CODE), {DIGITS{4'd9}}}
                                    : {sign_digit(a_neg_reg, r_nonzero, NEG_CODE), r_shift};
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (cout) begin
              err_reg       <= 1'b0;
              ovf_reg       <= 1'b0;
              res_reg       <= {sign_digit(a_neg_reg, r_nonzero, NEG_CODE), r_shift};
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              carry_reg <= 1'b1;
              state_reg <= FIX;
            end
          end
        end
        FIX: begin
          r_reg     <= r_shift;
          carry_reg <= cout;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (last_digit) begin
            idx_reg       <= '0;
            err_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            res_reg       <= {sign_digit(!a_neg_reg, r_nonzero, NEG_CODE), r_shift};
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.res       = res_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;
endmodule
